// File: rtl/replace_ctrl_pkg.sv
// Shared types for the miss-replacement sequencer: FSM state encoding and
// the default bound on how long a miss access may defer to pipeline hits.
package replace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WRITEBACK,
        REFILL,
        UPDATE
    } replace_state_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/replace_ctrl_victim_select.sv
// Combinational victim chooser. With REPLACE_INVALID_FIRST_EN defined the
// lowest-numbered invalid way wins over the PLRU choice; otherwise PLRU always wins.
module victim_select #(
    parameter int SET_SIZE  = 4,
    parameter int WAY_WIDTH = $clog2(SET_SIZE)
) (
    input  logic [SET_SIZE-1:0]  i_way_valid,
    input  logic [WAY_WIDTH-1:0] i_lru_way,
    output logic [WAY_WIDTH-1:0] o_victim
);

`ifdef REPLACE_INVALID_FIRST_EN
    // Scan from the top down so the lowest invalid way is the last one written.
    always_comb begin
        o_victim = i_lru_way;
        for (int i = SET_SIZE - 1; i >= 0; i--) begin
            if (!i_way_valid[i]) o_victim = WAY_WIDTH'(i);
        end
    end
`else
    logic w_unused;
    assign w_unused = ^i_way_valid;
    assign o_victim = i_lru_way;
`endif

endmodule

// File: rtl/replace_ctrl.sv
// Miss-replacement sequencer: victim choice, writeback/refill handshakes, PLRU commit,
// and arbitration of the shared PLRU port (victim policy set by REPLACE_INVALID_FIRST_EN).
module replace_ctrl
    import replace_pkg::*;
#(
    parameter int SET_SIZE    = 4,
    parameter int GROUP_NUM   = 128,
    parameter int WAY_WIDTH   = $clog2(SET_SIZE),
    parameter int INDEX_WIDTH = $clog2(GROUP_NUM),
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hit_valid,
    input  logic [INDEX_WIDTH-1:0] hit_index,
    input  logic [WAY_WIDTH-1:0]   hit_way,
    output logic                   hit_ready,
    input  logic                   miss_valid,
    input  logic [INDEX_WIDTH-1:0] miss_index,
    output logic                   miss_ready,
    output logic [INDEX_WIDTH-1:0] set_index,
    input  logic [SET_SIZE-1:0]    way_valid,
    input  logic [SET_SIZE-1:0]    way_dirty,
    input  logic [WAY_WIDTH-1:0]   lru_way,
    output logic                   plru_valid,
    output logic [INDEX_WIDTH-1:0] plru_index,
    output logic [WAY_WIDTH-1:0]   plru_ask_way,
    output logic                   wb_req,
    output logic [WAY_WIDTH-1:0]   wb_way,
    input  logic                   wb_ack,
    output logic                   refill_req,
    output logic [WAY_WIDTH-1:0]   refill_way,
    input  logic                   refill_done,
    output logic                   miss_done,
    output logic [WAY_WIDTH-1:0]   victim_way
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    replace_state_t         r_state;
    replace_state_t         w_next;
    logic [STARVE_W-1:0]    r_starve;
    logic [INDEX_WIDTH-1:0] r_set_index;
    logic [WAY_WIDTH-1:0]   r_victim;
    logic [WAY_WIDTH-1:0]   w_victim;
    logic                   w_port_state;
    logic                   w_owned;
    logic                   w_victim_dirty;

    victim_select #(
        .SET_SIZE  (SET_SIZE),
        .WAY_WIDTH (WAY_WIDTH)
    ) u_victim_select (
        .i_way_valid (way_valid),
        .i_lru_way   (lru_way),
        .o_victim    (w_victim)
    );

    // The miss path takes the PLRU port when no hit competes or it has waited long enough.
    assign w_port_state   = (r_state == SELECT) || (r_state == UPDATE);
    assign w_owned        = w_port_state && (!hit_valid || (r_starve == STARVE_W'(STARVE_MAX)));
    assign w_victim_dirty = way_valid[w_victim] && way_dirty[w_victim];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (miss_valid)  w_next = SELECT;
            SELECT:    if (w_owned)     w_next = w_victim_dirty ? WRITEBACK : REFILL;
            WRITEBACK: if (wb_ack)      w_next = REFILL;
            REFILL:    if (refill_done) w_next = UPDATE;
            UPDATE:    if (w_owned)     w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve    <= '0;
            r_set_index <= '0;
            r_victim    <= '0;
        end else begin
            if (r_state == IDLE && miss_valid) r_set_index <= miss_index;
            if (r_state == SELECT && w_owned)  r_victim    <= w_victim;
            if (w_port_state && !w_owned) r_starve <= r_starve + 1'b1;
            else                          r_starve <= '0;
        end
    end

    always_comb begin
        hit_ready    = !w_owned;
        plru_valid   = hit_valid;
        plru_index   = hit_index;
        plru_ask_way = hit_way;
        miss_done    = 1'b0;
        if (w_owned) begin
            plru_index   = r_set_index;
            plru_ask_way = r_victim;
            plru_valid   = (r_state == UPDATE);
            miss_done    = (r_state == UPDATE);
        end
        miss_ready = (r_state == IDLE);
        wb_req     = (r_state == WRITEBACK);
        refill_req = (r_state == REFILL);
    end

    assign set_index  = r_set_index;
    assign wb_way     = r_victim;
    assign refill_way = r_victim;
    assign victim_way = r_victim;

endmodule

// File: tb/tb_replace_ctrl.sv
// Randomised self-checking bench for replace_ctrl; expectations come from a
// transaction-level model of victim choice, handshake phases and hit starvation.
module tb_replace_ctrl;

    localparam int STARVE = 4;

    logic       clk;
    logic       reset;
    logic       hit_valid;
    logic [6:0] hit_index;
    logic [1:0] hit_way;
    logic       hit_ready;
    logic       miss_valid;
    logic [6:0] miss_index;
    logic       miss_ready;
    logic [6:0] set_index;
    logic [3:0] way_valid;
    logic [3:0] way_dirty;
    logic [1:0] lru_way;
    logic       plru_valid;
    logic [6:0] plru_index;
    logic [1:0] plru_ask_way;
    logic       wb_req;
    logic [1:0] wb_way;
    logic       wb_ack;
    logic       refill_req;
    logic [1:0] refill_way;
    logic       refill_done;
    logic       miss_done;
    logic [1:0] victim_way;

    int checkCount = 0;
    int errCount   = 0;

    replace_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hit_valid    (hit_valid),
        .hit_index    (hit_index),
        .hit_way      (hit_way),
        .hit_ready    (hit_ready),
        .miss_valid   (miss_valid),
        .miss_index   (miss_index),
        .miss_ready   (miss_ready),
        .set_index    (set_index),
        .way_valid    (way_valid),
        .way_dirty    (way_dirty),
        .lru_way      (lru_way),
        .plru_valid   (plru_valid),
        .plru_index   (plru_index),
        .plru_ask_way (plru_ask_way),
        .wb_req       (wb_req),
        .wb_way       (wb_way),
        .wb_ack       (wb_ack),
        .refill_req   (refill_req),
        .refill_way   (refill_way),
        .refill_done  (refill_done),
        .miss_done    (miss_done),
        .victim_way   (victim_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Victim the replacement policy should pick for a set.
    function automatic int refVictim(input logic [3:0] vld, input int lru);
`ifdef REPLACE_INVALID_FIRST_EN
        for (int i = 0; i < 4; i++) begin
            if (!vld[i]) return i;
        end
`endif
        return lru;
    endfunction

    task automatic clearInputs();
        hit_valid   = 1'b0;
        hit_index   = '0;
        hit_way     = '0;
        miss_valid  = 1'b0;
        miss_index  = '0;
        way_valid   = '0;
        way_dirty   = '0;
        lru_way     = '0;
        wb_ack      = 1'b0;
        refill_done = 1'b0;
    endtask

    task automatic randomHit();
        hit_valid = 1'($urandom_range(0, 1));
        hit_index = 7'($urandom);
        hit_way   = 2'($urandom);
    endtask

    // One complete miss transaction; called at a falling edge, returns at a falling edge.
    task automatic applyStimulus(input logic [6:0] idx, input logic [3:0] vld, input logic [3:0] drt,
                                 input logic [1:0] lru, input int hitsSel, input int wbDelay,
                                 input int refDelay, input int hitsUpd);
        int pend;
        int defer;
        int ev;
        bit expWb;
        clearInputs();
        miss_valid = 1'b1;
        miss_index = idx;
        way_valid  = vld;
        way_dirty  = drt;
        lru_way    = lru;
        randomHit();
        #1;
        checkOutput("idle_miss_ready", 32'(miss_ready), 1);
        checkOutput("idle_hit_ready", 32'(hit_ready), 1);
        checkOutput("idle_plru_valid", 32'(plru_valid), 32'(hit_valid));
        checkOutput("idle_plru_index", 32'(plru_index), 32'(hit_index));
        @(negedge clk);

        pend  = hitsSel;
        defer = (pend < STARVE) ? pend : STARVE;
        for (int c = 0; c <= defer; c++) begin
            miss_valid  = 1'($urandom_range(0, 1));
            miss_index  = 7'($urandom);
            wb_ack      = 1'($urandom_range(0, 1));
            refill_done = 1'($urandom_range(0, 1));
            hit_valid   = (pend > 0);
            hit_index   = 7'($urandom);
            hit_way     = 2'($urandom);
            lru_way     = (c == defer) ? lru : 2'($urandom);
            #1;
            if (c < defer) begin
                checkOutput("sel_defer_hit_ready", 32'(hit_ready), 1);
                checkOutput("sel_defer_plru_valid", 32'(plru_valid), 1);
                checkOutput("sel_defer_plru_index", 32'(plru_index), 32'(hit_index));
                checkOutput("sel_defer_plru_way", 32'(plru_ask_way), 32'(hit_way));
                pend--;
            end else begin
                checkOutput("sel_own_hit_ready", 32'(hit_ready), 0);
                checkOutput("sel_own_plru_valid", 32'(plru_valid), 0);
                checkOutput("sel_own_plru_index", 32'(plru_index), 32'(idx));
            end
            checkOutput("sel_set_index", 32'(set_index), 32'(idx));
            checkOutput("sel_miss_ready", 32'(miss_ready), 0);
            checkOutput("sel_refill_req", 32'(refill_req), 0);
            checkOutput("sel_wb_req", 32'(wb_req), 0);
            @(negedge clk);
        end

        ev    = refVictim(vld, int'(lru));
        expWb = vld[ev] && drt[ev];

        if (expWb) begin
            for (int c = 0; c <= wbDelay; c++) begin
                miss_valid  = 1'($urandom_range(0, 1));
                refill_done = 1'($urandom_range(0, 1));
                wb_ack      = (c == wbDelay);
                randomHit();
                #1;
                checkOutput("wb_req", 32'(wb_req), 1);
                checkOutput("wb_way", 32'(wb_way), 32'(ev));
                checkOutput("wb_refill_req", 32'(refill_req), 0);
                checkOutput("wb_hit_ready", 32'(hit_ready), 1);
                checkOutput("wb_plru_valid", 32'(plru_valid), 32'(hit_valid));
                @(negedge clk);
            end
        end

        for (int c = 0; c <= refDelay; c++) begin
            miss_valid  = 1'($urandom_range(0, 1));
            wb_ack      = 1'($urandom_range(0, 1));
            refill_done = (c == refDelay);
            randomHit();
            #1;
            checkOutput("refill_req", 32'(refill_req), 1);
            checkOutput("refill_way", 32'(refill_way), 32'(ev));
            checkOutput("refill_wb_req", 32'(wb_req), 0);
            checkOutput("refill_miss_done", 32'(miss_done), 0);
            checkOutput("refill_victim_way", 32'(victim_way), 32'(ev));
            checkOutput("refill_set_index", 32'(set_index), 32'(idx));
            @(negedge clk);
        end

        pend  = hitsUpd;
        defer = (pend < STARVE) ? pend : STARVE;
        for (int c = 0; c <= defer; c++) begin
            miss_valid  = 1'($urandom_range(0, 1));
            wb_ack      = 1'($urandom_range(0, 1));
            refill_done = 1'($urandom_range(0, 1));
            hit_valid   = (pend > 0);
            hit_index   = 7'($urandom);
            hit_way     = 2'($urandom);
            #1;
            if (c < defer) begin
                checkOutput("upd_defer_miss_done", 32'(miss_done), 0);
                checkOutput("upd_defer_hit_ready", 32'(hit_ready), 1);
                checkOutput("upd_defer_plru_index", 32'(plru_index), 32'(hit_index));
                pend--;
            end else begin
                checkOutput("upd_miss_done", 32'(miss_done), 1);
                checkOutput("upd_plru_valid", 32'(plru_valid), 1);
                checkOutput("upd_plru_index", 32'(plru_index), 32'(idx));
                checkOutput("upd_plru_way", 32'(plru_ask_way), 32'(ev));
                checkOutput("upd_hit_ready", 32'(hit_ready), 0);
            end
            checkOutput("upd_refill_req", 32'(refill_req), 0);
            @(negedge clk);
        end

        clearInputs();
        #1;
        checkOutput("done_miss_ready", 32'(miss_ready), 1);
        checkOutput("done_miss_done", 32'(miss_done), 0);
        @(negedge clk);
    endtask

    task automatic resetMidRefill();
        clearInputs();
        miss_valid = 1'b1;
        miss_index = 7'd9;
        way_valid  = 4'hF;
        lru_way    = 2'd1;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_pre_refill_req", 32'(refill_req), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_refill_req", 32'(refill_req), 0);
        checkOutput("rst_miss_ready", 32'(miss_ready), 1);
        checkOutput("rst_wb_req", 32'(wb_req), 0);
        checkOutput("rst_set_index", 32'(set_index), 0);
        checkOutput("rst_victim_way", 32'(victim_way), 0);
        refill_done = 1'b1;
        @(negedge clk);
        refill_done = 1'b0;
        #1;
        checkOutput("rst_late_miss_done", 32'(miss_done), 0);
        checkOutput("rst_late_miss_ready", 32'(miss_ready), 1);
        checkOutput("rst_late_refill_req", 32'(refill_req), 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_miss_ready", 32'(miss_ready), 1);
        checkOutput("reset_hit_ready", 32'(hit_ready), 1);
        checkOutput("reset_wb_req", 32'(wb_req), 0);
        checkOutput("reset_refill_req", 32'(refill_req), 0);
        checkOutput("reset_miss_done", 32'(miss_done), 0);
        checkOutput("reset_plru_valid", 32'(plru_valid), 0);
        checkOutput("reset_set_index", 32'(set_index), 0);
        checkOutput("reset_victim_way", 32'(victim_way), 0);
        @(negedge clk);

        applyStimulus(7'd5,  4'b1011, 4'b0000, 2'd0, 0, 0, 0, 0);
        applyStimulus(7'd17, 4'b1111, 4'b0000, 2'd3, 0, 0, 4, 0);
        applyStimulus(7'd33, 4'b1111, 4'b0010, 2'd1, 0, 3, 1, 0);
        applyStimulus(7'd64, 4'b1111, 4'b0000, 2'd2, 10, 0, 0, 10);
        applyStimulus(7'd99, 4'b0000, 4'b1111, 2'd2, 2, 0, 2, 3);
        resetMidRefill();

        for (int n = 0; n < 40; n++) begin
            applyStimulus(7'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
                          $urandom_range(0, 6), $urandom_range(0, 3),
                          $urandom_range(0, 4), $urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
